// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 cascade driver.
// The frame width is fixed by the two-chip cascade on the board.
package hc595_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int FRAME_W         = 16;
    localparam int BYTE_W          = 8;
    localparam int BIT_CNT_W       = $clog2(FRAME_W);
    localparam int CLK_DIV_DEFAULT = 2;

    // Bits needed to count 0 .. 2*clk_div-1.
    function automatic int phase_width(input int clk_div);
        return (clk_div <= 1) ? 1 : $clog2(2 * clk_div);
    endfunction

endpackage

// File: rtl/hc595_phase_gen.sv
// Bit-period phase counter: runs 0..2*CLK_DIV-1 while enabled, held at 0 otherwise.
// Decoded strobes mark the data-change, clock-rise and end-of-period phases.
module hc595_phase_gen
    import hc595_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int PH_W    = phase_width(CLK_DIV)
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            run,
    output logic [PH_W-1:0] phase,
    output logic            phase_zero,
    output logic            phase_mid,
    output logic            phase_last
);

    logic [PH_W-1:0] phase_reg;
    logic [PH_W-1:0] phase_next;

    assign phase_zero = (phase_reg == '0);
    assign phase_mid  = (phase_reg == PH_W'(CLK_DIV));
    assign phase_last = (phase_reg == PH_W'(2 * CLK_DIV - 1));
    assign phase      = phase_reg;

    always_comb begin
        phase_next = '0;
        if (run) begin
            phase_next = phase_last ? '0 : phase_reg + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end

endmodule

// File: rtl/hc595_ctrl.sv
// Serialises the scanner's {seg, sel} pair into two cascaded 74HC595s,
// one 16-bit frame after another, with registered pin outputs.
module hc595_ctrl
    import hc595_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [BYTE_W-1:0] sel,
    input  logic [BYTE_W-1:0] seg,
    input  logic              seg_en,
    output logic              shcp,
    output logic              stcp,
    output logic              ds,
    output logic              oe,
    output logic              busy,
    output logic              frame_done
);

    localparam int PH_W = phase_width(CLK_DIV);

    state_t                 state_reg, state_next;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [FRAME_W-1:0]     shadow_reg, shadow_next;
    logic                   shcp_reg, shcp_next;
    logic                   stcp_reg, stcp_next;
    logic                   ds_reg, ds_next;
    logic                   oe_reg, oe_next;
    logic                   busy_reg, busy_next;
    logic                   frame_done_reg, frame_done_next;

    logic [PH_W-1:0]        phase;
    logic                   phase_zero;
    logic                   phase_mid;
    logic                   phase_last;
    logic                   phase_run;

    assign phase_run = (state_reg == SHIFT) || (state_reg == LATCH);

    hc595_phase_gen #(
        .CLK_DIV (CLK_DIV),
        .PH_W    (PH_W)
    ) u_phase_gen (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .run        (phase_run),
        .phase      (phase),
        .phase_zero (phase_zero),
        .phase_mid  (phase_mid),
        .phase_last (phase_last)
    );

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shadow_next     = shadow_reg;
        shcp_next       = shcp_reg;
        stcp_next       = 1'b0;
        ds_next         = ds_reg;
        frame_done_next = 1'b0;
        oe_next         = ~seg_en;

        case (state_reg)
            IDLE: begin
                state_next = LOAD;
            end
            LOAD: begin
                shadow_next  = {seg, sel};
                bit_cnt_next = '0;
                state_next   = SHIFT;
            end
            SHIFT: begin
                if (phase_zero) begin
                    ds_next   = shadow_reg[FRAME_W-1];
                    shcp_next = 1'b0;
                end
                if (phase_mid) begin
                    shcp_next   = 1'b1;
                    shadow_next = shadow_reg << 1;
                end
                if (phase_last) begin
                    if (bit_cnt_reg == BIT_CNT_W'(FRAME_W - 1)) begin
                        state_next = LATCH;
                        // With CLK_DIV=1 the last rise shares this phase; let it through.
                        if (!phase_mid) begin
                            shcp_next = 1'b0;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            LATCH: begin
                shcp_next = 1'b0;
                stcp_next = (phase < PH_W'(CLK_DIV));
                if (phase_last) begin
                    frame_done_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shadow_reg     <= '0;
            shcp_reg       <= 1'b0;
            stcp_reg       <= 1'b0;
            ds_reg         <= 1'b0;
            oe_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shadow_reg     <= shadow_next;
            shcp_reg       <= shcp_next;
            stcp_reg       <= stcp_next;
            ds_reg         <= ds_next;
            oe_reg         <= oe_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign shcp       = shcp_reg;
    assign stcp       = stcp_reg;
    assign ds         = ds_reg;
    assign oe         = oe_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_hc595_ctrl.sv
// Bench for hc595_ctrl: a model of the two 595s feeds a scoreboard of expected
// latched frames; instance a runs CLK_DIV=2 directed frames, instance b CLK_DIV=1.
module tb_hc595_ctrl;

    logic       sys_clk = 1'b0;
    logic       rst_a_n, rst_b_n;
    logic [7:0] seg_a, sel_a, seg_b, sel_b;
    logic       seg_en_a, seg_en_b;
    logic       shcp_a, stcp_a, ds_a, oe_a, busy_a, frame_done_a;
    logic       shcp_b, stcp_b, ds_b, oe_b, busy_b, frame_done_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    hc595_ctrl #(.CLK_DIV(2)) dut_a (
        .sys_clk    (sys_clk),
        .sys_rst_n  (rst_a_n),
        .sel        (sel_a),
        .seg        (seg_a),
        .seg_en     (seg_en_a),
        .shcp       (shcp_a),
        .stcp       (stcp_a),
        .ds         (ds_a),
        .oe         (oe_a),
        .busy       (busy_a),
        .frame_done (frame_done_a)
    );

    hc595_ctrl #(.CLK_DIV(1)) dut_b (
        .sys_clk    (sys_clk),
        .sys_rst_n  (rst_b_n),
        .sel        (sel_b),
        .seg        (seg_b),
        .seg_en     (seg_en_b),
        .shcp       (shcp_b),
        .stcp       (stcp_b),
        .ds         (ds_b),
        .oe         (oe_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for instance a: two-chip 595 model plus frame timing checks.
    logic [15:0] sr_a = '0;
    logic        prev_shcp_a = 1'b0, prev_stcp_a = 1'b0, prev_busy_a = 1'b0, prev_ds_a = 1'b0;
    int          rises_a = 0, stcp_w_a = 0, busy_cyc_a = -1, done_cyc_a = -1;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (rst_a_n !== 1'b1) begin
                rises_a    = 0;
                stcp_w_a   = 0;
                busy_cyc_a = -1;
                done_cyc_a = -1;
            end else begin
                if (shcp_a && !prev_shcp_a) begin
                    sr_a = {sr_a[14:0], ds_a};
                    rises_a++;
                end
                if (ds_a !== prev_ds_a) check("a_ds_change_shcp_low", shcp_a, 0);
                if (stcp_a) stcp_w_a++;
                if (stcp_a && !prev_stcp_a) begin
                    check("a_stcp_rise_shcp_low", shcp_a, 0);
                    check("a_shcp_rises", rises_a, 16);
                    rises_a = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_frame: unexpected stcp rise, latched %h (cycle %0d)", sr_a, cyc);
                    end else begin
                        check("a_frame", sr_a, exp_q.pop_front());
                    end
                end
                if (!stcp_a && prev_stcp_a) begin
                    check("a_stcp_width", stcp_w_a, 2);
                    stcp_w_a = 0;
                end
                if (busy_a && !prev_busy_a) busy_cyc_a = cyc;
                if (frame_done_a) begin
                    if (busy_cyc_a >= 0) check("a_done_after_load", cyc - busy_cyc_a, 69);
                    if (done_cyc_a >= 0) check("a_frame_period", cyc - done_cyc_a, 70);
                    done_cyc_a = cyc;
                end
            end
            prev_shcp_a = shcp_a;
            prev_stcp_a = stcp_a;
            prev_busy_a = busy_a;
            prev_ds_a   = ds_a;
        end
    end

    // Monitor for instance b (CLK_DIV=1, constant inputs 5A/C3).
    logic [15:0] sr_b = '0;
    logic        prev_shcp_b = 1'b0, prev_stcp_b = 1'b0, prev_busy_b = 1'b0, prev_ds_b = 1'b0;
    int          rises_b = 0, stcp_w_b = 0, busy_cyc_b = -1, done_cyc_b = -1;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (rst_b_n === 1'b1) begin
                if (shcp_b && !prev_shcp_b) begin
                    sr_b = {sr_b[14:0], ds_b};
                    rises_b++;
                end
                if (ds_b !== prev_ds_b) check("b_ds_change_shcp_low", shcp_b, 0);
                if (stcp_b && shcp_b) check("b_stcp_shcp_overlap", {stcp_b, shcp_b}, 2'b10);
                if (stcp_b) stcp_w_b++;
                if (stcp_b && !prev_stcp_b) begin
                    check("b_shcp_rises", rises_b, 16);
                    check("b_frame", sr_b, 16'h5AC3);
                    rises_b = 0;
                end
                if (!stcp_b && prev_stcp_b) begin
                    check("b_stcp_width", stcp_w_b, 1);
                    stcp_w_b = 0;
                end
                if (busy_b && !prev_busy_b) busy_cyc_b = cyc;
                if (frame_done_b) begin
                    if (busy_cyc_b >= 0) check("b_done_after_load", cyc - busy_cyc_b, 35);
                    if (done_cyc_b >= 0) check("b_frame_period", cyc - done_cyc_b, 36);
                    done_cyc_b = cyc;
                end
            end
            prev_shcp_b = shcp_b;
            prev_stcp_b = stcp_b;
            prev_busy_b = busy_b;
            prev_ds_b   = ds_b;
        end
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (frame_done_a !== 1'b1 && n < 200);
        if (frame_done_a !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_done not seen within %0d cycles", tag, n);
        end
    endtask

    // Issued at a frame boundary (IDLE cycle), so the next LOAD captures sg/sl.
    task automatic run_frame(input logic [7:0] sg, input logic [7:0] sl, input logic [15:0] exp,
                             input bit mid, input logic [7:0] mid_seg);
        seg_a = sg;
        sel_a = sl;
        exp_q.push_back(exp);
        if (mid) begin
            repeat (20) @(negedge sys_clk);
            seg_a = mid_seg;
        end
        wait_done("frame_done_wait");
    endtask

    initial begin
        rst_a_n  = 1'b0;
        rst_b_n  = 1'b0;
        seg_a    = 8'hC0;
        sel_a    = 8'h01;
        seg_en_a = 1'b1;
        seg_b    = 8'h5A;
        sel_b    = 8'hC3;
        seg_en_b = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_shcp", shcp_a, 0);
        check("rst_stcp", stcp_a, 0);
        check("rst_ds", ds_a, 0);
        check("rst_oe", oe_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_frame_done", frame_done_a, 0);

        exp_q.push_back(16'hC001);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        wait_done("first_frame");

        run_frame(8'hA4, 8'h20, 16'hA420, 1'b0, 8'h00);
        run_frame(8'hF9, 8'h40, 16'hF940, 1'b1, 8'h92);
        run_frame(8'h92, 8'h40, 16'h9240, 1'b0, 8'h00);

        // Abort a frame in bit 7 (shcp high, ds = seg[0] = 1); no stcp may follow.
        seg_a = 8'h99;
        sel_a = 8'h08;
        repeat (33) @(negedge sys_clk);
        check("abort_busy_before", busy_a, 1);
        check("abort_shcp_before", shcp_a, 1);
        check("abort_ds_before", ds_a, 1);
        rst_a_n = 1'b0;
        exp_q.delete();
        @(negedge sys_clk);
        check("abort_shcp", shcp_a, 0);
        check("abort_stcp", stcp_a, 0);
        check("abort_ds", ds_a, 0);
        check("abort_oe", oe_a, 1);
        check("abort_busy", busy_a, 0);
        check("abort_frame_done", frame_done_a, 0);
        repeat (2) @(negedge sys_clk);
        seg_a = 8'hB0;
        sel_a = 8'h04;
        exp_q.push_back(16'hB004);
        rst_a_n = 1'b1;
        wait_done("after_abort");

        // seg_en toggles mid-frame; oe lags by one clock, frame cadence unchanged.
        seg_a = 8'hC6;
        sel_a = 8'h80;
        exp_q.push_back(16'hC680);
        repeat (10) @(negedge sys_clk);
        seg_en_a = 1'b0;
        check("oe_before_edge_on", oe_a, 0);
        @(negedge sys_clk);
        check("oe_off", oe_a, 1);
        repeat (10) @(negedge sys_clk);
        seg_en_a = 1'b1;
        check("oe_before_edge_off", oe_a, 1);
        @(negedge sys_clk);
        check("oe_on", oe_a, 0);
        wait_done("seg_en_frame");

        run_frame(8'h88, 8'h10, 16'h8810, 1'b0, 8'h00);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
